gpr_seq: RTL and testbench
==========================

GPR_SEQ -- requirements
Module: gpr_seq

Interface
REQ-001 Parameter DATA_W, default 14, sets the register data width.
REQ-002 Parameter ADDR_W, default 12, sets the register-file address width.
REQ-003 Parameter REG_W, default 4, sets the register index width.
REQ-004 clk  input  1  sole clock; all state changes on the rising edge.
REQ-005 rst  input  1  reset; asynchronous, active-high.
REQ-006 cmd_valid  input  1  a command is presented.
REQ-007 cmd_ready  output  1  the sequencer accepts a command this cycle.
REQ-008 cmd_op  input  2  opcode: 0 NOP, 1 WRI (write immediate), 2 SUM (sum, no writeback), 3 SUMW (sum with writeback).
REQ-009 cmd_ra, cmd_rb, cmd_rc, cmd_rd  input  REG_W each  source indices a/b/c and destination index.
REQ-010 cmd_imm  input  DATA_W  immediate value for WRI.
REQ-011 gpr_addr  output  ADDR_W  register-file address.
REQ-012 gpr_data  output  DATA_W  register-file write data.
REQ-013 gpr_rd, gpr_wr  output  1 each  register-file read strobe and write strobe.
REQ-014 gpr_q  input  DATA_W  registered three-operand sum from the register file, valid one cycle after the gpr_rd edge.
REQ-015 res_valid  output  1  single-cycle pulse marking res_data valid.
REQ-016 res_data  output  DATA_W  sum result.
REQ-017 done_cnt  output  8  count of completed non-NOP commands.

Function
REQ-018 The FSM SHALL have states IDLE, READ, WAIT and WRITE.
REQ-019 cmd_ready SHALL equal (state==IDLE) AND NOT rst.
REQ-020 A command SHALL be accepted only on an edge where cmd_valid and cmd_ready are both high; op, ra, rb, rc, rd and imm SHALL be latched at that edge.
REQ-021 NOP SHALL be accepted and SHALL stay in IDLE, with no strobe and no count change.
REQ-022 WRI SHALL go IDLE->WRITE.
REQ-023 SUM and SUMW SHALL go IDLE->READ->WAIT->WRITE.
REQ-024 WRITE SHALL always return to IDLE.
REQ-025 In READ, gpr_rd SHALL be 1 and gpr_addr SHALL equal {ra,rb,rc}: ra in bits [11:8], rb in [7:4], rc in [3:0].
REQ-026 In WAIT, gpr_rd SHALL be 0, and gpr_q SHALL be captured into the result register at the WAIT->WRITE edge.
REQ-027 In WRITE for WRI, gpr_wr SHALL be 1, gpr_addr SHALL equal {8'b0, rd} and gpr_data SHALL equal imm.
REQ-028 In WRITE for SUMW, gpr_wr SHALL be 1, gpr_addr SHALL equal {8'b0, rd}, and gpr_data SHALL equal the captured result.
REQ-029 In WRITE for SUMW, res_valid SHALL be 1.
REQ-030 In WRITE for SUM, gpr_wr SHALL be 0 and res_valid SHALL be 1.
REQ-031 Outside these cases, gpr_rd, gpr_wr and res_valid SHALL be 0, gpr_addr SHALL be 0, and gpr_data SHALL be 0.
REQ-032 res_data SHALL hold the last captured sum until the next capture.
REQ-033 Latency: WRI SHALL assert gpr_wr in cycle 1 after acceptance, with cmd_ready high again in cycle 2.
REQ-034 Latency: SUM and SUMW SHALL assert gpr_rd in cycle 1 and res_valid in cycle 3, with cmd_ready high again in cycle 4.
REQ-035 Sum arithmetic is performed in the register file modulo 2^DATA_W; the sequencer SHALL pass gpr_q through unmodified.
REQ-036 done_cnt SHALL increment by 1 at each WRITE->IDLE edge and SHALL wrap from 255 to 0.
REQ-037 Commands SHALL be strictly serialized; a read of a register written by the preceding command SHALL observe the new value.
REQ-038 cmd_valid held high while cmd_ready is low SHALL have no effect, and the held command SHALL be accepted on return to IDLE.
REQ-039 Equal source indices (e.g. ra=rb=rc) SHALL be legal and SHALL be passed unchanged.

Reset
REQ-040 While rst is high: state SHALL be IDLE, and cmd_ready, gpr_rd, gpr_wr, res_valid, gpr_addr, gpr_data, res_data and done_cnt SHALL all be 0.
REQ-041 Reset asserted in any state SHALL abort the command with no further gpr_wr pulse and no res_valid pulse.
REQ-042 The first command SHALL be accepted on the first edge with rst low and cmd_valid high.

Verification
REQ-043 After reset, WRI rd=3 imm=0x155 -> cycle 1: gpr_wr=1, gpr_addr=0x003, gpr_data=0x155; done_cnt=1.
REQ-044 SUMW ra=1 rb=2 rc=3 rd=4 with model gpr_q=0x0A0 -> gpr_rd=1 with gpr_addr=0x123 in cycle 1; cycle 3: gpr_wr=1, gpr_addr=0x004, gpr_data=0x0A0, res_valid=1, res_data=0x0A0.
REQ-045 SUM with gpr_q=0x3FFF -> res_valid=1 and res_data=0x3FFF with gpr_wr=0; next cycle cmd_ready=1.
REQ-046 cmd_valid held high with 3 back-to-back SUMW commands -> acceptances 4 cycles apart and exactly 3 gpr_wr pulses.
REQ-047 Reset asserted during WAIT of SUMW -> outputs 0 immediately, no gpr_wr, done_cnt=0, and a WRI is accepted on the first edge after release.
REQ-048 256 WRI commands -> done_cnt returns to 0; interleaved NOPs leave done_cnt unchanged.

Source files
------------

// File: rtl/gpr_seq_if.sv
// Command, register-file and result signals of the GPR sequencer, bundled so
// the sequencer and whatever drives it share one typed connection.
interface gpr_seq_if #(
    parameter int DATA_W = 14,
    parameter int ADDR_W = 12,
    parameter int REG_W  = 4
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [REG_W-1:0]  cmd_ra;
    logic [REG_W-1:0]  cmd_rb;
    logic [REG_W-1:0]  cmd_rc;
    logic [REG_W-1:0]  cmd_rd;
    logic [DATA_W-1:0] cmd_imm;
    logic [ADDR_W-1:0] gpr_addr;
    logic [DATA_W-1:0] gpr_data;
    logic              gpr_rd;
    logic              gpr_wr;
    logic [DATA_W-1:0] gpr_q;
    logic              res_valid;
    logic [DATA_W-1:0] res_data;
    logic [7:0]        done_cnt;

    // Command issuer / register-file side.
    modport master (
        output cmd_valid, cmd_op, cmd_ra, cmd_rb, cmd_rc, cmd_rd, cmd_imm, gpr_q,
        input  cmd_ready, gpr_addr, gpr_data, gpr_rd, gpr_wr, res_valid, res_data, done_cnt
    );

    // Sequencer side.
    modport slave (
        input  cmd_valid, cmd_op, cmd_ra, cmd_rb, cmd_rc, cmd_rd, cmd_imm, gpr_q,
        output cmd_ready, gpr_addr, gpr_data, gpr_rd, gpr_wr, res_valid, res_data, done_cnt
    );
endinterface

// File: rtl/gpr_seq.sv
// GPR sequencer: accepts one command at a time and turns it into register-file
// read/write strobes. SUM/SUMW read three operands (the register file returns
// their sum one cycle later), WRI writes an immediate. Commands are serialized.
module gpr_seq #(
    parameter int DATA_W = 14,
    parameter int ADDR_W = 12,
    parameter int REG_W  = 4
) (
    input  logic     clk,
    input  logic     rst,
    gpr_seq_if.slave bus
);
    localparam logic [1:0] OP_NOP  = 2'd0;
    localparam logic [1:0] OP_WRI  = 2'd1;
    localparam logic [1:0] OP_SUM  = 2'd2;
    localparam logic [1:0] OP_SUMW = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WAIT  = 2'd2,
        WRITE = 2'd3
    } state_t;

    state_t            state;
    state_t            state_next;
    logic              ready;
    logic              accept;
    logic [1:0]        op_q;
    logic [REG_W-1:0]  ra_q;
    logic [REG_W-1:0]  rb_q;
    logic [REG_W-1:0]  rc_q;
    logic [REG_W-1:0]  rd_q;
    logic [DATA_W-1:0] imm_q;
    logic [DATA_W-1:0] res_q;
    logic [7:0]        done_q;

    // Ready is forced low during reset so nothing can be accepted then.
    assign ready  = (state == IDLE) && !rst;
    assign accept = bus.cmd_valid && ready;

    assign bus.cmd_ready = ready;
    assign bus.res_data  = res_q;
    assign bus.done_cnt  = done_q;

    // State register; reset aborts any command in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Capture the whole command on the accepting edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q  <= OP_NOP;
            ra_q  <= '0;
            rb_q  <= '0;
            rc_q  <= '0;
            rd_q  <= '0;
            imm_q <= '0;
        end else if (accept) begin
            op_q  <= bus.cmd_op;
            ra_q  <= bus.cmd_ra;
            rb_q  <= bus.cmd_rb;
            rc_q  <= bus.cmd_rc;
            rd_q  <= bus.cmd_rd;
            imm_q <= bus.cmd_imm;
        end
    end

    // The register file's sum is valid during WAIT; hold it until the next one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                 res_q <= '0;
        else if (state == WAIT)  res_q <= bus.gpr_q;
    end

    // Every command that reaches WRITE completes on leaving it; 8-bit wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                 done_q <= '0;
        else if (state == WRITE) done_q <= done_q + 8'd1;
    end

    // Next-state and strobe decode; strobes are purely a function of state.
    always_comb begin
        state_next    = state;
        bus.gpr_rd    = 1'b0;
        bus.gpr_wr    = 1'b0;
        bus.res_valid = 1'b0;
        bus.gpr_addr  = '0;
        bus.gpr_data  = '0;
        case (state)
            IDLE: begin
                if (accept) begin
                    case (bus.cmd_op)
                        OP_WRI:          state_next = WRITE;
                        OP_SUM, OP_SUMW: state_next = READ;
                        default:         state_next = IDLE;
                    endcase
                end
            end
            READ: begin
                bus.gpr_rd   = 1'b1;
                bus.gpr_addr = ADDR_W'({ra_q, rb_q, rc_q});
                state_next   = WAIT;
            end
            WAIT: begin
                state_next = WRITE;
            end
            WRITE: begin
                state_next = IDLE;
                if (op_q == OP_WRI) begin
                    bus.gpr_wr   = 1'b1;
                    bus.gpr_addr = ADDR_W'(rd_q);
                    bus.gpr_data = imm_q;
                end else if (op_q == OP_SUMW) begin
                    bus.gpr_wr    = 1'b1;
                    bus.gpr_addr  = ADDR_W'(rd_q);
                    bus.gpr_data  = res_q;
                    bus.res_valid = 1'b1;
                end else if (op_q == OP_SUM) begin
                    bus.res_valid = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end
endmodule

// File: tb/tb_gpr_seq.sv
// Testbench for gpr_seq: a behavioural register file answers reads with the
// registered three-operand sum; a command-level model predicts every cycle.
module tb_gpr_seq;
    localparam int DATA_W = 14;
    localparam int ADDR_W = 12;
    localparam int REG_W  = 4;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    gpr_seq_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .REG_W(REG_W)) bus ();

    gpr_seq #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .REG_W(REG_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Register-file environment: registered sum on read, write on strobe.
    logic [13:0] rf [16];
    always @(posedge clk) begin
        if (bus.gpr_rd)
            bus.gpr_q <= rf[bus.gpr_addr[11:8]] + rf[bus.gpr_addr[7:4]] + rf[bus.gpr_addr[3:0]];
        if (bus.gpr_wr)
            rf[bus.gpr_addr[3:0]] <= bus.gpr_data;
    end

    // Command-level model state.
    logic [13:0] model_rf [16];
    logic [13:0] model_res;
    logic [7:0]  exp_done;

    // Per-cycle observations after an accepted command (cycles 1..4).
    logic        o_rd [1:4];
    logic        o_wr [1:4];
    logic        o_rv [1:4];
    logic        o_rdy [1:4];
    logic [11:0] o_addr [1:4];
    logic [13:0] o_data [1:4];
    logic [13:0] o_res [1:4];
    logic [7:0]  o_done [1:4];
    logic        acc_ok;

    function automatic logic [13:0] model_sum(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
        return model_rf[a] + model_rf[b] + model_rf[c];
    endfunction

    task automatic model_commit(input logic [1:0] op, input logic [3:0] ra, input logic [3:0] rb,
                                input logic [3:0] rc, input logic [3:0] rd, input logic [13:0] imm);
        logic [13:0] s;
        s = model_sum(ra, rb, rc);
        if (op == 2'd1) model_rf[rd] = imm;
        if (op == 2'd3) model_rf[rd] = s;
        if (op >= 2'd2) model_res = s;
        if (op != 2'd0) exp_done = exp_done + 8'd1;
    endtask

    task automatic do_cmd(input logic [1:0] op, input logic [3:0] ra, input logic [3:0] rb,
                          input logic [3:0] rc, input logic [3:0] rd, input logic [13:0] imm);
        int n;
        @(negedge clk);
        bus.cmd_op = op; bus.cmd_ra = ra; bus.cmd_rb = rb; bus.cmd_rc = rc;
        bus.cmd_rd = rd; bus.cmd_imm = imm; bus.cmd_valid = 1'b1;
        n = 0;
        while (!bus.cmd_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        acc_ok = bus.cmd_ready;
        @(posedge clk);
        #1 bus.cmd_valid = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            o_rd[k] = bus.gpr_rd;     o_wr[k] = bus.gpr_wr;     o_rv[k] = bus.res_valid;
            o_rdy[k] = bus.cmd_ready; o_addr[k] = bus.gpr_addr; o_data[k] = bus.gpr_data;
            o_res[k] = bus.res_data;  o_done[k] = bus.done_cnt;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        bus.cmd_valid = 1'b1; bus.cmd_op = 2'd1; bus.cmd_ra = '0; bus.cmd_rb = '0;
        bus.cmd_rc = '0; bus.cmd_rd = 4'd1; bus.cmd_imm = 14'h1234;
        repeat (2) @(negedge clk);
        checks++; if (bus.cmd_ready !== 1'b0) begin failures++; $display("FAIL reset_ready: got %0h want 0", bus.cmd_ready); end
        checks++; if ({bus.gpr_rd, bus.gpr_wr, bus.res_valid} !== 3'b000) begin failures++; $display("FAIL reset_strobes: got %b want 000", {bus.gpr_rd, bus.gpr_wr, bus.res_valid}); end
        checks++; if (bus.gpr_addr !== 12'h000) begin failures++; $display("FAIL reset_addr: got %h want 000", bus.gpr_addr); end
        checks++; if (bus.gpr_data !== 14'h0000) begin failures++; $display("FAIL reset_data: got %h want 0000", bus.gpr_data); end
        checks++; if (bus.res_data !== 14'h0000) begin failures++; $display("FAIL reset_res: got %h want 0000", bus.res_data); end
        checks++; if (bus.done_cnt !== 8'h00) begin failures++; $display("FAIL reset_done: got %h want 00", bus.done_cnt); end
        model_res = '0;
        exp_done  = '0;
    endtask

    task automatic test_wri_after_reset;
        // Release reset and present WRI on the same low phase: first edge accepts it.
        rst = 1'b0;
        bus.cmd_valid = 1'b1; bus.cmd_op = 2'd1; bus.cmd_rd = 4'd3; bus.cmd_imm = 14'h155;
        @(posedge clk);
        #1 bus.cmd_valid = 1'b0;
        @(negedge clk);
        checks++; if (bus.gpr_wr !== 1'b1) begin failures++; $display("FAIL wri_wr: got %0h want 1", bus.gpr_wr); end
        checks++; if (bus.gpr_addr !== 12'h003) begin failures++; $display("FAIL wri_addr: got %h want 003", bus.gpr_addr); end
        checks++; if (bus.gpr_data !== 14'h155) begin failures++; $display("FAIL wri_data: got %h want 155", bus.gpr_data); end
        checks++; if (bus.cmd_ready !== 1'b0) begin failures++; $display("FAIL wri_busy: got %0h want 0", bus.cmd_ready); end
        @(negedge clk);
        checks++; if (bus.cmd_ready !== 1'b1) begin failures++; $display("FAIL wri_ready2: got %0h want 1", bus.cmd_ready); end
        checks++; if (bus.done_cnt !== 8'd1) begin failures++; $display("FAIL wri_done: got %0d want 1", bus.done_cnt); end
        model_commit(2'd1, 4'd0, 4'd0, 4'd0, 4'd3, 14'h155);
    endtask

    task automatic test_sumw;
        do_cmd(2'd1, 4'd0, 4'd0, 4'd0, 4'd1, 14'h020); model_commit(2'd1, 4'd0, 4'd0, 4'd0, 4'd1, 14'h020);
        do_cmd(2'd1, 4'd0, 4'd0, 4'd0, 4'd2, 14'h030); model_commit(2'd1, 4'd0, 4'd0, 4'd0, 4'd2, 14'h030);
        do_cmd(2'd1, 4'd0, 4'd0, 4'd0, 4'd3, 14'h050); model_commit(2'd1, 4'd0, 4'd0, 4'd0, 4'd3, 14'h050);
        do_cmd(2'd3, 4'd1, 4'd2, 4'd3, 4'd4, 14'h000);
        model_commit(2'd3, 4'd1, 4'd2, 4'd3, 4'd4, 14'h000);
        checks++; if (acc_ok !== 1'b1) begin failures++; $display("FAIL sumw_accept: got %0h want 1", acc_ok); end
        checks++; if ({o_rd[1], o_addr[1]} !== {1'b1, 12'h123}) begin failures++; $display("FAIL sumw_read: got rd=%0h addr=%h want rd=1 addr=123", o_rd[1], o_addr[1]); end
        checks++; if ({o_rd[2], o_wr[2], o_rv[2], o_rdy[2]} !== 4'b0000) begin failures++; $display("FAIL sumw_wait: got %b want 0000", {o_rd[2], o_wr[2], o_rv[2], o_rdy[2]}); end
        checks++; if ({o_wr[3], o_addr[3], o_data[3]} !== {1'b1, 12'h004, 14'h0A0}) begin failures++; $display("FAIL sumw_write: got wr=%0h addr=%h data=%h want 1/004/0a0", o_wr[3], o_addr[3], o_data[3]); end
        checks++; if ({o_rv[3], o_res[3]} !== {1'b1, 14'h0A0}) begin failures++; $display("FAIL sumw_result: got rv=%0h res=%h want 1/0a0", o_rv[3], o_res[3]); end
        checks++; if ({o_rdy[4], o_rv[4], o_done[4]} !== {1'b1, 1'b0, exp_done}) begin failures++; $display("FAIL sumw_after: got rdy=%0h rv=%0h done=%0d want 1/0/%0d", o_rdy[4], o_rv[4], o_done[4], exp_done); end
    endtask

    task automatic test_sum;
        logic [13:0] s;
        do_cmd(2'd1, 4'd0, 4'd0, 4'd0, 4'd5, 14'h3FFF); model_commit(2'd1, 4'd0, 4'd0, 4'd0, 4'd5, 14'h3FFF);
        do_cmd(2'd1, 4'd0, 4'd0, 4'd0, 4'd6, 14'h0000); model_commit(2'd1, 4'd0, 4'd0, 4'd0, 4'd6, 14'h0000);
        do_cmd(2'd1, 4'd0, 4'd0, 4'd0, 4'd7, 14'h0000); model_commit(2'd1, 4'd0, 4'd0, 4'd0, 4'd7, 14'h0000);
        do_cmd(2'd2, 4'd5, 4'd6, 4'd7, 4'd9, 14'h0000); model_commit(2'd2, 4'd5, 4'd6, 4'd7, 4'd9, 14'h0000);
        checks++; if ({o_rv[3], o_res[3]} !== {1'b1, 14'h3FFF}) begin failures++; $display("FAIL sum_result: got rv=%0h res=%h want 1/3fff", o_rv[3], o_res[3]); end
        checks++; if ({o_wr[3], o_addr[3], o_data[3]} !== {1'b0, 12'h000, 14'h0000}) begin failures++; $display("FAIL sum_nowrite: got wr=%0h addr=%h data=%h want 0/000/0000", o_wr[3], o_addr[3], o_data[3]); end
        checks++; if ({o_rdy[4], o_res[4]} !== {1'b1, 14'h3FFF}) begin failures++; $display("FAIL sum_hold: got rdy=%0h res=%h want 1/3fff", o_rdy[4], o_res[4]); end
        // Equal indices, with the sum wrapping modulo 2^14.
        s = model_sum(4'd5, 4'd5, 4'd5);
        do_cmd(2'd2, 4'd5, 4'd5, 4'd5, 4'd0, 14'h0000); model_commit(2'd2, 4'd5, 4'd5, 4'd5, 4'd0, 14'h0000);
        checks++; if (o_addr[1] !== 12'h555) begin failures++; $display("FAIL sum_eqidx_addr: got %h want 555", o_addr[1]); end
        checks++; if (o_res[3] !== s) begin failures++; $display("FAIL sum_wrap: got %h want %h", o_res[3], s); end
    endtask

    task automatic test_back_to_back;
        int accepted;
        int wr_cnt;
        int rv_cnt;
        int acc_cyc [3];
        @(negedge clk);
        bus.cmd_op = 2'd3; bus.cmd_ra = 4'd1; bus.cmd_rb = 4'd2; bus.cmd_rc = 4'd4;
        bus.cmd_rd = 4'd8; bus.cmd_valid = 1'b1;
        accepted = 0; wr_cnt = 0; rv_cnt = 0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            if (bus.gpr_wr) wr_cnt++;
            if (bus.res_valid) rv_cnt++;
            if (bus.cmd_valid && bus.cmd_ready) begin
                acc_cyc[accepted] = cyc;
                accepted++;
            end
            @(posedge clk);
            #1 if (accepted == 3) bus.cmd_valid = 1'b0;
            @(negedge clk);
        end
        for (int i = 0; i < 3; i++) model_commit(2'd3, 4'd1, 4'd2, 4'd4, 4'd8, 14'h0000);
        checks++; if (accepted !== 3) begin failures++; $display("FAIL b2b_accepts: got %0d want 3", accepted); end
        if (accepted == 3) begin
            checks++; if ((acc_cyc[1] - acc_cyc[0]) !== 4 || (acc_cyc[2] - acc_cyc[1]) !== 4) begin failures++; $display("FAIL b2b_spacing: got %0d,%0d want 4,4", acc_cyc[1] - acc_cyc[0], acc_cyc[2] - acc_cyc[1]); end
        end
        checks++; if (wr_cnt !== 3 || rv_cnt !== 3) begin failures++; $display("FAIL b2b_pulses: got wr=%0d rv=%0d want 3/3", wr_cnt, rv_cnt); end
        checks++; if ({bus.res_data, bus.done_cnt} !== {model_res, exp_done}) begin failures++; $display("FAIL b2b_state: got res=%h done=%0d want %h/%0d", bus.res_data, bus.done_cnt, model_res, exp_done); end
    endtask

    task automatic test_reset_abort;
        int pulses;
        logic [13:0] imm;
        imm = 14'($urandom);
        @(negedge clk);
        bus.cmd_op = 2'd3; bus.cmd_ra = 4'd1; bus.cmd_rb = 4'd2; bus.cmd_rc = 4'd3;
        bus.cmd_rd = 4'd10; bus.cmd_valid = 1'b1;
        @(posedge clk);
        #1 bus.cmd_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++; if ({bus.gpr_rd, bus.gpr_wr, bus.res_valid} !== 3'b000) begin failures++; $display("FAIL abort_wait_strobes: got %b want 000", {bus.gpr_rd, bus.gpr_wr, bus.res_valid}); end
        #1 rst = 1'b1;
        #1;
        checks++; if ({bus.gpr_rd, bus.gpr_wr, bus.res_valid, bus.cmd_ready, bus.gpr_addr, bus.gpr_data} !== '0) begin failures++; $display("FAIL abort_outputs: got rd=%0h wr=%0h rv=%0h rdy=%0h addr=%h data=%h want all 0", bus.gpr_rd, bus.gpr_wr, bus.res_valid, bus.cmd_ready, bus.gpr_addr, bus.gpr_data); end
        checks++; if ({bus.res_data, bus.done_cnt} !== '0) begin failures++; $display("FAIL abort_regs: got res=%h done=%0d want 0/0", bus.res_data, bus.done_cnt); end
        model_res = '0;
        exp_done  = '0;
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (bus.gpr_wr || bus.res_valid) pulses++;
        end
        rst = 1'b0;
        bus.cmd_op = 2'd1; bus.cmd_rd = 4'd9; bus.cmd_imm = imm; bus.cmd_valid = 1'b1;
        @(posedge clk);
        #1 bus.cmd_valid = 1'b0;
        @(negedge clk);
        checks++; if (pulses !== 0) begin failures++; $display("FAIL abort_pulses: got %0d want 0", pulses); end
        checks++; if ({bus.gpr_wr, bus.gpr_addr, bus.gpr_data} !== {1'b1, 12'h009, imm}) begin failures++; $display("FAIL abort_first_wri: got wr=%0h addr=%h data=%h want 1/009/%h", bus.gpr_wr, bus.gpr_addr, bus.gpr_data, imm); end
        model_commit(2'd1, 4'd0, 4'd0, 4'd0, 4'd9, imm);
        @(negedge clk);
        checks++; if (bus.done_cnt !== exp_done) begin failures++; $display("FAIL abort_done: got %0d want %0d", bus.done_cnt, exp_done); end
    endtask

    task automatic test_wrap;
        logic [13:0] imm;
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        model_res = '0;
        exp_done  = '0;
        for (int i = 0; i < 256; i++) begin
            imm = 14'($urandom);
            do_cmd(2'd1, 4'd0, 4'd0, 4'd0, 4'(i), imm);
            model_commit(2'd1, 4'd0, 4'd0, 4'd0, 4'(i), imm);
            checks++; if (o_done[4] !== exp_done) begin failures++; $display("FAIL wrap_count_%0d: got %0d want %0d", i, o_done[4], exp_done); end
            if (i % 64 == 10) begin
                do_cmd(2'd0, 4'd1, 4'd2, 4'd3, 4'd4, imm);
                checks++; if ({o_rdy[1], o_rd[1], o_wr[1], o_rv[1], o_done[4]} !== {4'b1000, exp_done}) begin failures++; $display("FAIL wrap_nop_%0d: got rdy=%0h rd=%0h wr=%0h rv=%0h done=%0d want 1/0/0/0/%0d", i, o_rdy[1], o_rd[1], o_wr[1], o_rv[1], o_done[4], exp_done); end
            end
        end
        checks++; if (bus.done_cnt !== 8'd0) begin failures++; $display("FAIL wrap_zero: got %0d want 0", bus.done_cnt); end
    endtask

    task automatic test_random;
        logic [1:0]  op;
        logic [3:0]  ra, rb, rc, rd;
        logic [13:0] imm, s, old_res;
        logic [43:0] got, want;
        logic        e_rd, e_wr, e_rv, e_rdy;
        logic [11:0] e_addr;
        logic [13:0] e_data, e_res;
        for (int n = 0; n < 60; n++) begin
            op = 2'($urandom_range(0, 3));
            ra = 4'($urandom); rb = 4'($urandom); rc = 4'($urandom); rd = 4'($urandom);
            imm = 14'($urandom);
            s = model_sum(ra, rb, rc);
            old_res = model_res;
            do_cmd(op, ra, rb, rc, rd, imm);
            model_commit(op, ra, rb, rc, rd, imm);
            checks++; if (acc_ok !== 1'b1) begin failures++; $display("FAIL rand_accept_%0d: got %0h want 1", n, acc_ok); end
            for (int k = 1; k <= 4; k++) begin
                e_rd = 1'b0; e_wr = 1'b0; e_rv = 1'b0; e_rdy = 1'b1;
                e_addr = '0; e_data = '0; e_res = old_res;
                if (op == 2'd1 && k == 1) begin
                    e_wr = 1'b1; e_rdy = 1'b0; e_addr = {8'b0, rd}; e_data = imm;
                end
                if (op >= 2'd2) begin
                    if (k <= 3) e_rdy = 1'b0;
                    if (k >= 3) e_res = s;
                    if (k == 1) begin e_rd = 1'b1; e_addr = {ra, rb, rc}; end
                    if (k == 3) begin
                        e_rv = 1'b1;
                        if (op == 2'd3) begin e_wr = 1'b1; e_addr = {8'b0, rd}; e_data = s; end
                    end
                end
                got  = {o_rd[k], o_wr[k], o_rv[k], o_rdy[k], o_addr[k], o_data[k], o_res[k]};
                want = {e_rd, e_wr, e_rv, e_rdy, e_addr, e_data, e_res};
                checks++; if (got !== want) begin failures++; $display("FAIL rand_cmd%0d_op%0d_cyc%0d: got %h want %h (rd,wr,rv,rdy,addr,data,res)", n, op, k, got, want); end
            end
            checks++; if (o_done[4] !== exp_done) begin failures++; $display("FAIL rand_done_%0d: got %0d want %0d", n, o_done[4], exp_done); end
        end
    endtask

    initial begin
        bus.cmd_valid = 1'b0; bus.cmd_op = '0; bus.cmd_ra = '0; bus.cmd_rb = '0;
        bus.cmd_rc = '0; bus.cmd_rd = '0; bus.cmd_imm = '0;
        for (int i = 0; i < 16; i++) model_rf[i] = '0;
        test_reset;
        test_wri_after_reset;
        test_sumw;
        test_sum;
        test_back_to_back;
        test_reset_abort;
        test_wrap;
        test_random;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end
endmodule
